// File: rtl/fpu_issue_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_issue_sequencer
//
// Upstream issue stage for the Fixed_Point_Unit. It accepts one request over a
// valid/ready handshake and latches the operands. It holds the FPU operation
// and operands stable until the FPU reports ready. It then returns the result
// (with the request tag) to writeback over a second valid/ready handshake.
//
// After every response, one RECOVER cycle forces the FPU operation to ADD, so
// the FPU multiplier FSM always sees a non-MUL cycle and restarts cleanly. A
// watchdog turns an operation that never completes into an error response.
//
// Handshake rule (both ports): a transfer happens on the rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge. This block never drops req_ready or rsp_valid while a
// transfer is pending.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   req_valid/ready  request handshake (req_ready is high only in IDLE)
//   req_op           FPU_ADD / FPU_SUB / FPU_MUL / FPU_SQRT
//   req_a, req_b     operands (req_b is unused by SQRT but is still driven)
//   req_tag          destination register id, echoed on rsp_tag
//   fpu_operand_1/2  operands to the FPU, zero outside ISSUE/WAIT
//   fpu_operation    operation to the FPU, ADD outside ISSUE/WAIT
//   fpu_start        one-cycle pulse in the ISSUE cycle
//   fpu_result       result from the FPU
//   fpu_ready        ready from the FPU
//   rsp_valid/ready  response handshake
//   rsp_result       captured result (0 on watchdog error)
//   rsp_tag          tag of the completed request
//   rsp_error        1 when the watchdog expired
//   busy             high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module fpu_issue_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  output logic             fpu_start,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error,
  output logic             busy
);

  // Operation codes shared with the Fixed_Point_Unit.
  localparam logic [1:0] FPU_ADD  = 2'b00;
  localparam logic [1:0] FPU_SUB  = 2'b01;
  localparam logic [1:0] FPU_MUL  = 2'b10;
  localparam logic [1:0] FPU_SQRT = 2'b11;

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] wd_cnt;   // ISSUE/WAIT cycles already completed

  logic [CNT_W-1:0] wd_next;
  logic             in_op;
  logic             is_add_sub;
  logic             capture;
  logic             expire;

  // fpu_operation holds the latched op during ISSUE/WAIT, so the decode below
  // reads from it directly. ADD and SUB are the two codes with bit 1 clear.
  always_comb begin
    wd_next    = wd_cnt + 1'b1;
    in_op      = (state == S_ISSUE) || (state == S_WAIT);
    is_add_sub = (fpu_operation == FPU_ADD) || (fpu_operation == FPU_SUB);
    capture    = 1'b0;
    case (state)
      // In the ISSUE cycle, a ready seen for MUL/SQRT is left over from the
      // previous operation, so only the combinational ADD/SUB path can finish.
      S_ISSUE: capture = is_add_sub && fpu_ready;
      S_WAIT:  capture = fpu_ready;
      default: capture = 1'b0;
    endcase
    // This cycle is the wd_next-th cycle of the op. A capture in the same
    // cycle takes priority over expiry, which the state machine enforces.
    expire = in_op && (wd_next >= TIMEOUT_LIM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      tag_q         <= '0;
      wd_cnt        <= '0;
      req_ready     <= 1'b1;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      fpu_operation <= FPU_ADD;
      fpu_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_tag       <= '0;
      rsp_error     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready is high for the whole IDLE state.
          if (req_valid) begin
            state         <= S_ISSUE;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            fpu_operation <= req_op;
            fpu_operand_1 <= req_a;
            fpu_operand_2 <= req_b;
            fpu_start     <= 1'b1;
            tag_q         <= req_tag;
            wd_cnt        <= '0;
          end
        end

        S_ISSUE, S_WAIT: begin
          fpu_start <= 1'b0;
          if (capture || expire) begin
            state         <= S_RESP;
            rsp_valid     <= 1'b1;
            rsp_result    <= capture ? fpu_result : '0;
            rsp_error     <= ~capture;
            rsp_tag       <= tag_q;
            // Drop the FPU inputs to the idle values as soon as the op ends.
            fpu_operation <= FPU_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
          end else begin
            state  <= S_WAIT;
            wd_cnt <= wd_next;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_RECOVER;
            rsp_valid <= 1'b0;
          end
        end

        // The FPU inputs already idle at ADD/0 here. This cycle only
        // guarantees the multiplier sees a non-MUL op before the next request.
        S_RECOVER: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state         <= S_IDLE;
          req_ready     <= 1'b1;
          busy          <= 1'b0;
          rsp_valid     <= 1'b0;
          fpu_start     <= 1'b0;
          fpu_operation <= FPU_ADD;
          fpu_operand_1 <= '0;
          fpu_operand_2 <= '0;
        end
      endcase
    end
  end

endmodule
